adder_serial: RTL and testbench



---
 rtl/adder_serial_if.sv | 22 ++
 rtl/adder_serial.sv | 71 +++++++
 tb/tb_adder_serial.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adder_serial_if.sv
// adder_serial_if: operand/result handshake bundle for the digit-serial adder
interface adder_serial_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_serial.sv
// adder_serial: digit-serial adder/subtractor resolving DIGIT bits per clock, LSB first
module adder_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic          clk,
    input logic          rst,
    adder_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic [DIGIT:0]   dsum;
    logic             last;
    assign dsum = {1'b0, a_r[cnt*DIGIT +: DIGIT]} + {1'b0, b_r[cnt*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, carry};
    assign last = cnt == CW'(N - 1);
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    // accept operands, ripple one digit per cycle, then hold the result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r   <= bus.a;
                    b_r   <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.cin ^ bus.sub;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    sum_r[cnt*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
                    carry <= dsum[DIGIT];
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state       <= DONE;
                        cout_r      <= dsum[DIGIT];
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (dsum[DIGIT-1] != a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_serial.sv
// tb_adder_serial: directed checks of the digit-serial adder in 4-bit and 16-bit digit configurations
module tb_adder_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    adder_serial_if #(.WIDTH(16)) b4 ();
    adder_serial_if #(.WIDTH(16)) b16 ();
    adder_serial #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
    adder_serial #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    // free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_out(input string tag);
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
        chk({tag, " out_valid_cleared"}, b4.out_valid, 0);
        chk({tag, " in_ready_after"}, b4.in_ready, 1);
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic [15:0] es,
                      input logic ec, input logic eo, input bit rel);
        int lat;
        chk({tag, " in_ready_idle"}, b4.in_ready, 1);
        b4.a = a; b4.b = b; b4.cin = cin; b4.sub = sub; b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0; b4.a = 16'hDEAD; b4.b = 16'hBEEF; b4.cin = ~cin; b4.sub = ~sub;
        chk({tag, " in_ready_busy"}, b4.in_ready, 0);
        lat = 0;
        while (!b4.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " sum"}, b4.sum, es);
        chk({tag, " cout"}, b4.cout, ec);
        chk({tag, " ovf"}, b4.ovf, eo);
        if (rel) release_out(tag);
    endtask

    initial begin
        int lat;
        b4.in_valid = 0; b4.a = 0; b4.b = 0; b4.cin = 0; b4.sub = 0; b4.out_ready = 0;
        b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.cin = 0; b16.sub = 0; b16.out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst out_valid", b4.out_valid, 0);
        chk("rst sum", b4.sum, 0);
        chk("rst cout", b4.cout, 0);
        chk("rst ovf", b4.ovf, 0);
        chk("rst in_ready", b4.in_ready, 1);
        chk("rst16 in_ready", b16.in_ready, 1);
        op("basic_add", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 1);
        op("ripple", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        op("sub_borrow", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 1);
        op("sub_bin", 16'h0009, 16'h0003, 1, 1, 16'h0005, 1, 0, 1);
        op("ovf_add", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1);
        op("ovf_sub", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 1);
        op("add_cin", 16'h00FF, 16'h0000, 1, 0, 16'h0100, 0, 0, 1);
        op("bp", 16'h00F0, 16'h000F, 0, 0, 16'h00FF, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            b4.in_valid = i[0];
            b4.a = 16'($urandom);
            b4.b = 16'($urandom);
            @(posedge clk); #1;
            chk("bp sum", b4.sum, 16'h00FF);
            chk("bp cout", b4.cout, 0);
            chk("bp ovf", b4.ovf, 0);
            chk("bp in_ready", b4.in_ready, 0);
            chk("bp out_valid", b4.out_valid, 1);
        end
        b4.in_valid = 1'b0;
        release_out("bp");
        repeat (6) @(posedge clk);
        #1;
        chk("bp no_capture valid", b4.out_valid, 0);
        chk("bp no_capture ready", b4.in_ready, 1);
        b4.a = 16'hFFFF; b4.b = 16'h0001; b4.cin = 0; b4.sub = 0; b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out_valid", b4.out_valid, 0);
        chk("midrst in_ready", b4.in_ready, 1);
        chk("midrst sum", b4.sum, 0);
        chk("midrst cout", b4.cout, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst quiet", b4.out_valid, 0);
        end
        op("post_rst", 16'h0010, 16'h0020, 0, 0, 16'h0030, 0, 0, 1);
        b16.a = 16'h1234; b16.b = 16'h4321; b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        lat = 0;
        while (!b16.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("d16 latency", lat, 1);
        chk("d16 sum", b16.sum, 16'h5555);
        chk("d16 cout", b16.cout, 0);
        chk("d16 ovf", b16.ovf, 0);
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        chk("d16 in_ready_after", b16.in_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
